// File: rtl/pulpemu_rst_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pulpemu_rst_pkg
// Description : Shared types and defaults for the emulation reset sequencer.
//               Provides the sequencer state encoding, the default timing
//               constants for a 125 MHz board clock and a helper that sizes
//               the shared sequencer counter.
// Revision    : 1.0 - initial release
// ============================================================================
package pulpemu_rst_pkg;

    // Sequencer states. The encoding is visible on state_o, so it is fixed.
    typedef enum logic [2:0] {
        ST_MMCM_RST  = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_SETTLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_LOCK_ERR  = 3'd4
    } rst_state_e;

    // Defaults for a 125 MHz clock.
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 1250000;  // 10 ms
    localparam int unsigned DEF_MMCM_RST_CYCLES = 16;
    localparam int unsigned DEF_LOCK_TIMEOUT    = 125000;   // 1 ms
    localparam int unsigned DEF_SETTLE_CYCLES   = 1024;
    localparam int unsigned DEF_MAX_RETRIES     = 3;

    // Width needed for a counter that must reach (max(a,b,c) - 1).
    // Never returns less than one bit.
    function automatic int unsigned cnt_width(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pulpemu_rst_seq_debounce.sv
`default_nettype none
// ============================================================================
// Module      : pulpemu_debounce
// Description : Two-flop synchroniser followed by a stability filter. The
//               filtered output only changes once the synchronised input has
//               disagreed with it for DEBOUNCE_CYCLES consecutive cycles; any
//               agreeing sample restarts the count.
// Ports       : clk_i   - sampling clock
//               rstn_i  - asynchronous active-low reset
//               i_din   - raw asynchronous input
//               o_dout  - debounced level (resets to 0)
// Revision    : 1.0 - initial release
// ============================================================================
module pulpemu_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1250000
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic i_din,
    output logic o_dout
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       r_sync;
    logic             r_db;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_sync <= 2'b00;
            r_db   <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_sync <= {r_sync[0], i_din};
            if (r_sync[1] != r_db) begin
                // The disagreeing sample that completes the run flips the output.
                if (r_cnt == c_LAST) begin
                    r_db  <= ~r_db;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_dout = r_db;

endmodule
`default_nettype wire

// File: rtl/pulpemu_rst_seq.sv
`default_nettype none
// ============================================================================
// Module      : pulpemu_rst_seq
// Description : Power-up / recovery reset sequencer for the FPGA emulation
//               top. Releases the clock manager, the reference-clock divider
//               and the PULP chip reset in order, retries the clock manager
//               when lock is late, and re-sequences when lock is lost.
// Ports       : clk_i          - buffered 125 MHz free-running clock
//               rstn_i         - asynchronous active-low reset
//               btn_rst_i      - raw board reset button, active-high
//               mmcm_locked_i  - clock manager lock, asynchronous
//               mmcm_rstn_o    - clock manager reset, active-low
//               ref_div_rstn_o - reference divider reset, active-low
//               soc_rstn_o     - PULP chip reset, active-low
//               lock_err_o     - sticky lock-failure flag
//               state_o        - current sequencer state
//               retry_cnt_o    - retries consumed in the current sequence
// Revision    : 1.0 - initial release
// ============================================================================
module pulpemu_rst_seq
    import pulpemu_rst_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned MMCM_RST_CYCLES = DEF_MMCM_RST_CYCLES,
    parameter int unsigned LOCK_TIMEOUT    = DEF_LOCK_TIMEOUT,
    parameter int unsigned SETTLE_CYCLES   = DEF_SETTLE_CYCLES,
    parameter int unsigned MAX_RETRIES     = DEF_MAX_RETRIES    // must fit retry_cnt_o (<= 3)
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic       btn_rst_i,
    input  logic       mmcm_locked_i,
    output logic       mmcm_rstn_o,
    output logic       ref_div_rstn_o,
    output logic       soc_rstn_o,
    output logic       lock_err_o,
    output logic [2:0] state_o,
    output logic [1:0] retry_cnt_o
);

    localparam int unsigned CNT_W = cnt_width(MMCM_RST_CYCLES, LOCK_TIMEOUT, SETTLE_CYCLES);

    localparam logic [CNT_W-1:0] c_MMCM_LAST   = CNT_W'(MMCM_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] c_SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_CNT_SAT     = '1;
    localparam logic [1:0]       c_MAX_RETRY   = 2'(MAX_RETRIES);

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic       w_btn_db;
    logic [1:0] r_lock_sync;
    logic       w_lock_s;

    pulpemu_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn_db (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .i_din  (btn_rst_i),
        .o_dout (w_btn_db)
    );

    // Lock is already a level from the clock manager; it only needs to be
    // brought into this clock domain, not filtered.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_lock_sync <= 2'b00;
        end else begin
            r_lock_sync <= {r_lock_sync[0], mmcm_locked_i};
        end
    end

    assign w_lock_s = r_lock_sync[1];

    // ------------------------------------------------------------------
    // Sequencer state
    // ------------------------------------------------------------------
    rst_state_e       r_state;
    rst_state_e       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [1:0]       r_retry;
    logic [1:0]       w_retry_nxt;

    logic r_mmcm_rstn,   w_mmcm_rstn_nxt;
    logic r_ref_rstn,    w_ref_rstn_nxt;
    logic r_soc_rstn,    w_soc_rstn_nxt;
    logic r_lock_err,    w_lock_err_nxt;

    // A failed attempt either consumes a retry or gives up.
    function automatic rst_state_e retry_or_fail(input logic [1:0] retry);
        return (retry == c_MAX_RETRY) ? ST_LOCK_ERR : ST_MMCM_RST;
    endfunction

    always_comb begin
        w_state_nxt = r_state;
        w_retry_nxt = r_retry;

        if (w_btn_db) begin
            w_state_nxt = ST_MMCM_RST;
            w_retry_nxt = 2'd0;
        end else begin
            case (r_state)
                ST_MMCM_RST: begin
                    if (r_cnt == c_MMCM_LAST) begin
                        w_state_nxt = ST_WAIT_LOCK;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (w_lock_s) begin
                        w_state_nxt = ST_SETTLE;
                    end else if (r_cnt == c_LOCK_LAST) begin
                        w_state_nxt = retry_or_fail(r_retry);
                        if (r_retry != c_MAX_RETRY) begin
                            w_retry_nxt = r_retry + 2'd1;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (!w_lock_s) begin
                        w_state_nxt = retry_or_fail(r_retry);
                        if (r_retry != c_MAX_RETRY) begin
                            w_retry_nxt = r_retry + 2'd1;
                        end
                    end else if (r_cnt == c_SETTLE_LAST) begin
                        w_state_nxt = ST_RUN;
                        w_retry_nxt = 2'd0;
                    end
                end
                ST_RUN: begin
                    // Losing lock after a good boot is not a failed attempt.
                    if (!w_lock_s) begin
                        w_state_nxt = ST_MMCM_RST;
                    end
                end
                ST_LOCK_ERR: begin
                    w_state_nxt = ST_LOCK_ERR;
                end
                default: begin
                    w_state_nxt = ST_MMCM_RST;
                end
            endcase
        end

        // Shared counter: restarts on every state change, held at zero while
        // the button is down, and sticks at all-ones rather than wrapping.
        if (w_btn_db || (w_state_nxt != r_state)) begin
            w_cnt_nxt = '0;
        end else if (r_cnt != c_CNT_SAT) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
        end else begin
            w_cnt_nxt = r_cnt;
        end

        // Outputs decode the next state so they switch on the same edge as
        // state_o and come straight out of flops.
        w_mmcm_rstn_nxt = (w_state_nxt == ST_WAIT_LOCK) ||
                          (w_state_nxt == ST_SETTLE)    ||
                          (w_state_nxt == ST_RUN);
        w_ref_rstn_nxt  = (w_state_nxt == ST_SETTLE) || (w_state_nxt == ST_RUN);
        w_soc_rstn_nxt  = (w_state_nxt == ST_RUN);
        w_lock_err_nxt  = (w_state_nxt == ST_LOCK_ERR);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state     <= ST_MMCM_RST;
            r_cnt       <= '0;
            r_retry     <= 2'd0;
            r_mmcm_rstn <= 1'b0;
            r_ref_rstn  <= 1'b0;
            r_soc_rstn  <= 1'b0;
            r_lock_err  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_retry     <= w_retry_nxt;
            r_mmcm_rstn <= w_mmcm_rstn_nxt;
            r_ref_rstn  <= w_ref_rstn_nxt;
            r_soc_rstn  <= w_soc_rstn_nxt;
            r_lock_err  <= w_lock_err_nxt;
        end
    end

    assign mmcm_rstn_o    = r_mmcm_rstn;
    assign ref_div_rstn_o = r_ref_rstn;
    assign soc_rstn_o     = r_soc_rstn;
    assign lock_err_o     = r_lock_err;
    assign state_o        = r_state;
    assign retry_cnt_o    = r_retry;

endmodule
`default_nettype wire

// File: tb/tb_pulpemu_rst_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_pulpemu_rst_seq
// Description : Self-checking bench for pulpemu_rst_seq. A phase/elapsed-time
//               model tracks where the sequence must be and is compared with
//               the DUT on every falling edge; directed scenarios add literal
//               edge-by-edge expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pulpemu_rst_seq;

    localparam int DB   = 5;
    localparam int MR   = 4;
    localparam int LT   = 20;
    localparam int SC   = 8;
    localparam int MAXR = 2;

    logic       clk_i         = 1'b0;
    logic       rstn_i        = 1'b0;
    logic       btn_rst_i     = 1'b0;
    logic       mmcm_locked_i = 1'b1;
    logic       mmcm_rstn_o;
    logic       ref_div_rstn_o;
    logic       soc_rstn_o;
    logic       lock_err_o;
    logic [2:0] state_o;
    logic [1:0] retry_cnt_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    pulpemu_rst_seq #(
        .DEBOUNCE_CYCLES (DB),
        .MMCM_RST_CYCLES (MR),
        .LOCK_TIMEOUT    (LT),
        .SETTLE_CYCLES   (SC),
        .MAX_RETRIES     (MAXR)
    ) dut (
        .clk_i          (clk_i),
        .rstn_i         (rstn_i),
        .btn_rst_i      (btn_rst_i),
        .mmcm_locked_i  (mmcm_locked_i),
        .mmcm_rstn_o    (mmcm_rstn_o),
        .ref_div_rstn_o (ref_div_rstn_o),
        .soc_rstn_o     (soc_rstn_o),
        .lock_err_o     (lock_err_o),
        .state_o        (state_o),
        .retry_cnt_o    (retry_cnt_o)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: phase number plus cycles elapsed in that phase.
    // Phases: 0 reset pulse, 1 wait lock, 2 settle, 3 run, 4 lock error.
    // ------------------------------------------------------------------
    typedef struct packed {
        logic b1, b2, l1, l2, db;
        int   run;      // consecutive samples disagreeing with db
        int   ph;
        int   t;        // edges spent in current phase
        int   retries;
    } mdl_t;

    mdl_t m;

    function automatic mdl_t step(input mdl_t c, input logic btn, input logic lk);
        mdl_t n;
        n    = c;
        n.b1 = btn;  n.b2 = c.b1;
        n.l1 = lk;   n.l2 = c.l1;
        if (c.b2 != c.db) begin
            n.run = c.run + 1;
            if (n.run == DB) begin
                n.db  = ~c.db;
                n.run = 0;
            end
        end else begin
            n.run = 0;
        end
        n.t = c.t + 1;
        if (c.db) begin
            n.ph = 0; n.t = 0; n.retries = 0;
        end else begin
            case (c.ph)
                0: if (c.t + 1 == MR) begin n.ph = 1; n.t = 0; end
                1: begin
                    if (c.l2) begin
                        n.ph = 2; n.t = 0;
                    end else if (c.t + 1 == LT) begin
                        n.t = 0;
                        if (c.retries == MAXR) n.ph = 4;
                        else begin n.ph = 0; n.retries = c.retries + 1; end
                    end
                end
                2: begin
                    if (!c.l2) begin
                        n.t = 0;
                        if (c.retries == MAXR) n.ph = 4;
                        else begin n.ph = 0; n.retries = c.retries + 1; end
                    end else if (c.t + 1 == SC) begin
                        n.ph = 3; n.t = 0; n.retries = 0;
                    end
                end
                3: if (!c.l2) begin n.ph = 0; n.t = 0; end
                default: ;
            endcase
        end
        return n;
    endfunction

    function automatic int mdl_out(input mdl_t c);
        logic mm, rf, sc, er;
        mm = (c.ph >= 1) && (c.ph <= 3);
        rf = (c.ph == 2) || (c.ph == 3);
        sc = (c.ph == 3);
        er = (c.ph == 4);
        return {23'd0, mm, rf, sc, er, c.ph[2:0], c.retries[1:0]};
    endfunction

    always @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) m <= '0;
        else         m <= step(m, btn_rst_i, mmcm_locked_i);
    end

    always @(negedge clk_i) begin
        chk("cycle_vs_model",
            {23'd0, mmcm_rstn_o, ref_div_rstn_o, soc_rstn_o, lock_err_o, state_o, retry_cnt_o},
            mdl_out(m));
    end

    // ------------------------------------------------------------------
    // Directed helpers
    // ------------------------------------------------------------------
    task automatic wait_state(input logic [2:0] s, input int limit, input string name);
        int n;
        n = 0;
        while (state_o != s && n < limit) begin
            @(negedge clk_i);
            n++;
        end
        chk(name, state_o, s);
    endtask

    // Clean boot from reset release with lock present: mmcm at edge 4,
    // divider at edge 5, chip at edge 13.
    task automatic check_boot(input string tag);
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk_i);
            chk({tag, "_mmcm"}, mmcm_rstn_o,    (i >= 4)  ? 1 : 0);
            chk({tag, "_ref"},  ref_div_rstn_o, (i >= 5)  ? 1 : 0);
            chk({tag, "_soc"},  soc_rstn_o,     (i >= 13) ? 1 : 0);
        end
        chk({tag, "_state"}, state_o, 3);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        rstn_i = 1'b0; btn_rst_i = 1'b0; mmcm_locked_i = 1'b1;
        repeat (3) @(negedge clk_i);
        chk("reset_state", state_o, 0);
        chk("reset_rstn",  {mmcm_rstn_o, ref_div_rstn_o, soc_rstn_o}, 0);
        chk("reset_err",   lock_err_o, 0);
        chk("reset_retry", retry_cnt_o, 0);

        // 1. Clean boot
        rstn_i = 1'b1;
        check_boot("boot1");

        // 3. One-cycle lock drop in RUN: chip reset falls 3 edges later
        mmcm_locked_i = 1'b0;
        @(negedge clk_i); mmcm_locked_i = 1'b1;
        chk("lossrun_soc_e1", soc_rstn_o, 1);
        @(negedge clk_i);
        chk("lossrun_soc_e2", soc_rstn_o, 1);
        @(negedge clk_i);
        chk("lossrun_soc_e3", soc_rstn_o, 0);
        chk("lossrun_ref_e3", ref_div_rstn_o, 0);
        chk("lossrun_state",  state_o, 0);
        chk("lossrun_retry",  retry_cnt_o, 0);
        wait_state(3'd3, 40, "lossrun_rerun");
        chk("lossrun_retry_end", retry_cnt_o, 0);

        // 4a. Short bounces are ignored
        for (int k = 0; k < 2; k++) begin
            btn_rst_i = 1'b1;
            repeat (3) @(negedge clk_i);
            btn_rst_i = 1'b0;
            repeat (4) @(negedge clk_i);
        end
        repeat (6) @(negedge clk_i);
        chk("bounce_run", state_o, 3);

        // 4b. 10-cycle press: sync 2 + debounce 5, state follows one edge later
        btn_rst_i = 1'b1;
        for (int i = 1; i <= 24; i++) begin
            @(negedge clk_i);
            if (i == 7)  chk("press_e7_state", state_o, 3);
            if (i == 8)  chk("press_e8_state", state_o, 0);
            if (i == 8)  chk("press_e8_rstn", {mmcm_rstn_o, ref_div_rstn_o, soc_rstn_o}, 0);
            if (i == 10) btn_rst_i = 1'b0;
            if (i == 17) chk("press_e17_state", state_o, 0);
            if (i == 20) chk("press_e20_mmcm", mmcm_rstn_o, 0);
            if (i == 21) chk("press_e21_state", state_o, 1);
        end
        wait_state(3'd3, 40, "press_rerun");

        // 2. No lock at all: three attempts then LOCK_ERR
        @(negedge clk_i);
        rstn_i = 1'b0; mmcm_locked_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rstn_i = 1'b1;
        for (int i = 1; i <= 75; i++) begin
            @(negedge clk_i);
            if (i == 3)  chk("retry_e3_mmcm",   mmcm_rstn_o, 0);
            if (i == 4)  chk("retry_e4_mmcm",   mmcm_rstn_o, 1);
            if (i == 23) chk("retry_e23_retry", retry_cnt_o, 0);
            if (i == 24) chk("retry_e24_mmcm",  mmcm_rstn_o, 0);
            if (i == 24) chk("retry_e24_retry", retry_cnt_o, 1);
            if (i == 27) chk("retry_e27_mmcm",  mmcm_rstn_o, 0);
            if (i == 28) chk("retry_e28_state", state_o, 1);
            if (i == 48) chk("retry_e48_retry", retry_cnt_o, 2);
            if (i == 51) chk("retry_e51_mmcm",  mmcm_rstn_o, 0);
            if (i == 71) chk("retry_e71_state", state_o, 1);
            if (i == 72) chk("retry_e72_state", state_o, 4);
            if (i == 72) chk("retry_e72_err",   lock_err_o, 1);
            if (i == 72) chk("retry_e72_rstn", {mmcm_rstn_o, ref_div_rstn_o, soc_rstn_o}, 0);
            if (i == 75) chk("retry_e75_state", state_o, 4);
        end

        // 5. Recovery from LOCK_ERR via the button
        mmcm_locked_i = 1'b1;
        repeat (5) @(negedge clk_i);
        chk("err_sticky_state", state_o, 4);
        chk("err_sticky_flag",  lock_err_o, 1);
        btn_rst_i = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk_i);
            if (i == 7) chk("recov_e7_err",   lock_err_o, 1);
            if (i == 8) chk("recov_e8_err",   lock_err_o, 0);
            if (i == 8) chk("recov_e8_retry", retry_cnt_o, 0);
        end
        btn_rst_i = 1'b0;
        wait_state(3'd3, 60, "recov_run");
        chk("recov_err_clear", lock_err_o, 0);

        // 6. Asynchronous reset in the middle of SETTLE
        @(negedge clk_i);
        rstn_i = 1'b0;
        @(negedge clk_i);
        rstn_i = 1'b1;
        repeat (8) @(negedge clk_i);
        chk("mid_settle_state", state_o, 2);
        #2 rstn_i = 1'b0;
        #1;
        chk("async_rstn",  {mmcm_rstn_o, ref_div_rstn_o, soc_rstn_o}, 0);
        chk("async_state", state_o, 0);
        chk("async_misc",  {lock_err_o, retry_cnt_o}, 0);
        @(negedge clk_i);
        rstn_i = 1'b1;
        check_boot("boot2");

        repeat (2) @(negedge clk_i);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
